// File: rtl/jk_reg_counter.sv
// WIDTH-bit bank of JK flip-flops with synchronous enable, parallel load and
// modulo up/down counting; registered terminal-count and change-detect flags.
module jk_reg_counter #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           MAX_COUNT = 255,
  parameter logic [WIDTH-1:0]      RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             chg
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             chg_q, chg_d;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (en) begin
      unique case (mode_sel)
        // Characteristic equation Q+ = J&~Q | ~K&Q applied bitwise.
        MODE_JK:   q_d = (j & ~q_q) | (~k & q_q);
        MODE_UP: begin
          if (q_q >= MAX_Q) begin
            q_d  = '0;
            tc_d = 1'b1;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (q_q == '0) begin
            q_d  = MAX_Q;
            tc_d = 1'b1;
          end else if (q_q > MAX_Q) begin
            q_d = MAX_Q;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
        MODE_LOAD: q_d = d;
        default:   q_d = q_q;
      endcase
    end
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RST_VAL;
      tc_q  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      chg_q <= chg_d;
    end
  end

  assign q   = q_q;
  assign qb  = ~q_q;
  assign tc  = tc_q;
  assign chg = chg_q;

endmodule
